pe_net_iface: RTL and testbench

// - Clocked network interface at one mesh node's PE port: the PE-side endpoint of the router's PE_in/PE_out links.
// - TX: packs PE requests into 57-bit packets; drives them to the router as 4-phase bundled data (req/ack).
// - RX: accepts 4-phase packets from the router, unpacks them and buffers them in a FIFO for the PE.
// - Packet: [56:53] dst, [52:49] src, [48:47] type, [46:0] payload.

---
 rtl/pe_net_iface.sv | 222 ++++++++++++++++++++++
 tb/tb_pe_net_iface.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_net_iface.sv
// pe_net_iface: PE-side network interface of one mesh node.
// TX packs PE requests into 57-bit packets and drives them to the router
// over a 4-phase req/ack link. RX accepts 4-phase packets from the router
// and queues them in a small FIFO for the PE.
// Optional feature macro: NI_DEST_CHECK_EN (drop and count packets whose
// dst field does not match NODE_ID).
module pe_net_iface #(
    parameter logic [3:0]  NODE_ID   = 4'd1,
    parameter int unsigned WIDTH_PKT = 57,
    parameter int unsigned RX_DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [3:0]           tx_dst,
    input  logic [1:0]           tx_type,
    input  logic [46:0]          tx_data,
    output logic                 net_out_req,
    output logic [WIDTH_PKT-1:0] net_out_data,
    input  logic                 net_out_ack,
    input  logic                 net_in_req,
    input  logic [WIDTH_PKT-1:0] net_in_data,
    output logic                 net_in_ack,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic [3:0]           rx_src,
    output logic [1:0]           rx_type,
    output logic [46:0]          rx_data,
    output logic [7:0]           drop_cnt
);

    localparam int unsigned AW = $clog2(RX_DEPTH);
    localparam int unsigned CW = AW + 1;
    // FIFO entries omit the dst field; the PE only needs src/type/payload
    localparam int unsigned EW = 53;

    if (WIDTH_PKT != 57) begin : g_bad_width
        $error("pe_net_iface: WIDTH_PKT must be 57");
    end
    if ((RX_DEPTH < 2) || ((RX_DEPTH & (RX_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("pe_net_iface: RX_DEPTH must be a power of 2 and >= 2");
    end

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SETUP,
        TX_REQ_HI,
        TX_REQ_LO
    } tx_state_t;

    typedef enum logic {
        RX_WAIT_REQ,
        RX_WAIT_REL
    } rx_state_t;

    tx_state_t tx_state;
    rx_state_t rx_state;

    logic [1:0]    ack_sync;
    logic [1:0]    req_sync;
    logic          ack_s;
    logic          req_s;

    logic [EW-1:0] mem [RX_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [EW-1:0] head;

    logic          full_c;
    logic          capture_c;
    logic          dst_ok_c;
    logic          push_c;
    logic          pop_c;

    // Two-flop synchronizers for the asynchronous handshake inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_sync <= 2'b00;
            req_sync <= 2'b00;
        end else begin
            ack_sync <= {ack_sync[0], net_out_ack};
            req_sync <= {req_sync[0], net_in_req};
        end
    end

    assign ack_s = ack_sync[1];
    assign req_s = req_sync[1];

    // TX FSM: accept, hold data one setup cycle, then full 4-phase cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state     <= TX_IDLE;
            tx_ready     <= 1'b1;
            net_out_req  <= 1'b0;
            net_out_data <= '0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (tx_valid) begin
                        net_out_data <= {tx_dst, NODE_ID, tx_type, tx_data};
                        tx_ready     <= 1'b0;
                        tx_state     <= TX_SETUP;
                    end
                end
                TX_SETUP: begin
                    net_out_req <= 1'b1;
                    tx_state    <= TX_REQ_HI;
                end
                TX_REQ_HI: begin
                    if (ack_s) begin
                        net_out_req <= 1'b0;
                        tx_state    <= TX_REQ_LO;
                    end
                end
                TX_REQ_LO: begin
                    if (!ack_s) begin
                        tx_ready <= 1'b1;
                        tx_state <= TX_IDLE;
                    end
                end
                default: begin
                    tx_state <= TX_IDLE;
                end
            endcase
        end
    end

    assign full_c    = (count == CW'(RX_DEPTH));
    assign capture_c = (rx_state == RX_WAIT_REQ) && req_s && !full_c;
    assign dst_ok_c  = (net_in_data[56:53] == NODE_ID);
    assign pop_c     = rx_valid && rx_ready;

`ifdef NI_DEST_CHECK_EN
    assign push_c = capture_c && dst_ok_c;

    // Saturating count of packets handshaken but discarded as misrouted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= 8'd0;
        end else if (capture_c && !dst_ok_c && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
`else
    logic unused_dst_ok;

    assign push_c        = capture_c;
    assign unused_dst_ok = dst_ok_c;
    assign drop_cnt      = 8'd0;
`endif

    // RX FSM: ack only when there is room, so a full FIFO back-pressures the router
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state   <= RX_WAIT_REQ;
            net_in_ack <= 1'b0;
        end else begin
            case (rx_state)
                RX_WAIT_REQ: begin
                    if (capture_c) begin
                        net_in_ack <= 1'b1;
                        rx_state   <= RX_WAIT_REL;
                    end
                end
                RX_WAIT_REL: begin
                    if (!req_s) begin
                        net_in_ack <= 1'b0;
                        rx_state   <= RX_WAIT_REQ;
                    end
                end
                default: begin
                    rx_state <= RX_WAIT_REQ;
                end
            endcase
        end
    end

    // Next FIFO occupancy; simultaneous push and pop leave it unchanged
    always_comb begin
        count_next = count;
        if (push_c && !pop_c) begin
            count_next = count + CW'(1);
        end else if (pop_c && !push_c) begin
            count_next = count - CW'(1);
        end
    end

    // FIFO pointers, occupancy and registered valid flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rx_valid <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count    <= count_next;
            rx_valid <= (count_next != '0);
        end
    end

    // FIFO storage; contents are qualified by count so no reset is needed
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= net_in_data[EW-1:0];
        end
    end

    assign head    = mem[rd_ptr];
    assign rx_src  = head[52:49];
    assign rx_type = head[48:47];
    assign rx_data = head[46:0];

endmodule

// File: tb/tb_pe_net_iface.sv
// Directed bench for pe_net_iface: TX/RX vector tables plus hand-written
// sequences for FIFO-full back-pressure, wrap, destination check and
// asynchronous reset in the middle of a handshake.
module tb_pe_net_iface;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tx_valid;
    logic        tx_ready;
    logic [3:0]  tx_dst;
    logic [1:0]  tx_type;
    logic [46:0] tx_data;
    logic        net_out_req;
    logic [56:0] net_out_data;
    logic        net_out_ack;
    logic        net_in_req;
    logic [56:0] net_in_data;
    logic        net_in_ack;
    logic        rx_valid;
    logic        rx_ready;
    logic [3:0]  rx_src;
    logic [1:0]  rx_type;
    logic [46:0] rx_data;
    logic [7:0]  drop_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [3:0]  dst;
        logic [1:0]  typ;
        logic [46:0] data;
        logic [56:0] exp_pkt;
    } tx_vec_t;

    typedef struct {
        logic [3:0]  src;
        logic [1:0]  typ;
        logic [46:0] data;
    } rx_vec_t;

    tx_vec_t tx_vec[3];
    rx_vec_t rx_vec[3];
    rx_vec_t fifo_vec[5];
    rx_vec_t exp_q[$];

    pe_net_iface #(
        .NODE_ID  (4'd1),
        .WIDTH_PKT(57),
        .RX_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_dst      (tx_dst),
        .tx_type     (tx_type),
        .tx_data     (tx_data),
        .net_out_req (net_out_req),
        .net_out_data(net_out_data),
        .net_out_ack (net_out_ack),
        .net_in_req  (net_in_req),
        .net_in_data (net_in_data),
        .net_in_ack  (net_in_ack),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_src      (rx_src),
        .rx_type     (rx_type),
        .rx_data     (rx_data),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [56:0] mk(input logic [3:0] d, input logic [3:0] s,
                                       input logic [1:0] t, input logic [46:0] p);
        return {d, s, t, p};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Router side of the TX link; entered just after a falling edge
    task automatic tx_send(input tx_vec_t v);
        int i;
        check("tx_ready_idle", 64'(tx_ready), 64'd1);
        tx_valid = 1'b1;
        tx_dst   = v.dst;
        tx_type  = v.typ;
        tx_data  = v.data;
        @(negedge clk);
        tx_valid = 1'b0;
        check("tx_setup_req_low", 64'(net_out_req), 64'd0);
        check("tx_pkt", 64'(net_out_data), 64'(v.exp_pkt));
        check("tx_busy", 64'(tx_ready), 64'd0);
        @(negedge clk);
        check("tx_req_rise_2cyc", 64'(net_out_req), 64'd1);
        net_out_ack = 1'b1;
        i = 0;
        while (net_out_req && i < 20) begin @(negedge clk); i++; end
        check("tx_req_fall", 64'(net_out_req), 64'd0);
        check("tx_no_accept_ack_hi", 64'(tx_ready), 64'd0);
        net_out_ack = 1'b0;
        i = 0;
        while (!tx_ready && i < 20) begin @(negedge clk); i++; end
        check("tx_ready_return", 64'(tx_ready), 64'd1);
        check("tx_pkt_held", 64'(net_out_data), 64'(v.exp_pkt));
    endtask

    task automatic rx_raise(input logic [56:0] pkt);
        net_in_data = pkt;
        net_in_req  = 1'b1;
    endtask

    task automatic rx_wait_ack(input int bound, output int cycles);
        cycles = 0;
        while (!net_in_ack && cycles < bound) begin @(negedge clk); cycles++; end
    endtask

    task automatic rx_release();
        int i;
        net_in_req = 1'b0;
        i = 0;
        while (net_in_ack && i < 20) begin @(negedge clk); i++; end
        check("rx_ack_fall", 64'(net_in_ack), 64'd0);
    endtask

    task automatic rx_send(input logic [56:0] pkt);
        int c;
        rx_raise(pkt);
        rx_wait_ack(20, c);
        check("rx_ack", 64'(net_in_ack), 64'd1);
        rx_release();
    endtask

    task automatic pop_check(input string name, input rx_vec_t v);
        check({name, "_valid"}, 64'(rx_valid), 64'd1);
        check({name, "_src"},   64'(rx_src),   64'(v.src));
        check({name, "_type"},  64'(rx_type),  64'(v.typ));
        check({name, "_data"},  64'(rx_data),  64'(v.data));
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    initial begin
        int c;
        rx_vec_t dv;

        tx_vec[0] = '{4'd7, 2'd2, 47'h1234, 57'h0E3_0000_0000_1234};
        tx_vec[1] = '{4'd15, 2'd3, 47'h7FFF_FFFF_FFFF, mk(4'd15, 4'd1, 2'd3, 47'h7FFF_FFFF_FFFF)};
        tx_vec[2] = '{4'd0, 2'd0, 47'h0, mk(4'd0, 4'd1, 2'd0, 47'h0)};

        rx_vec[0] = '{4'd9, 2'd0, 47'hABC};
        rx_vec[1] = '{4'd15, 2'd3, 47'h5555_AAAA_5555};
        rx_vec[2] = '{4'd2, 2'd1, 47'h0};

        for (int i = 0; i < 5; i++) begin
            fifo_vec[i] = '{4'(i + 3), 2'(i), 47'(32'h100 + i)};
        end

        rst_n       = 1'b0;
        tx_valid    = 1'b0;
        tx_dst      = '0;
        tx_type     = '0;
        tx_data     = '0;
        net_out_ack = 1'b0;
        net_in_req  = 1'b0;
        net_in_data = '0;
        rx_ready    = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_net_out_req",  64'(net_out_req),  64'd0);
        check("rst_net_out_data", 64'(net_out_data), 64'd0);
        check("rst_net_in_ack",   64'(net_in_ack),   64'd0);
        check("rst_tx_ready",     64'(tx_ready),     64'd1);
        check("rst_rx_valid",     64'(rx_valid),     64'd0);
        check("rst_drop_cnt",     64'(drop_cnt),     64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // TX vector table
        for (int i = 0; i < 3; i++) begin
            tx_send(tx_vec[i]);
            @(negedge clk);
        end

        // RX vector table: 3-cycle ack latency, head visible with ack
        for (int i = 0; i < 3; i++) begin
            rx_raise(mk(4'd1, rx_vec[i].src, rx_vec[i].typ, rx_vec[i].data));
            rx_wait_ack(20, c);
            check("rx_ack_latency", 64'(c), 64'd3);
            check("rx_valid_at_ack", 64'(rx_valid), 64'd1);
            rx_release();
            pop_check("rx_head", rx_vec[i]);
            check("rx_empty_after_pop", 64'(rx_valid), 64'd0);
        end

        // FIFO full: four accepted, fifth held until a pop
        for (int i = 0; i < 4; i++) begin
            rx_send(mk(4'd1, fifo_vec[i].src, fifo_vec[i].typ, fifo_vec[i].data));
        end
        rx_raise(mk(4'd1, fifo_vec[4].src, fifo_vec[4].typ, fifo_vec[4].data));
        rx_wait_ack(10, c);
        check("full_backpressure", 64'(net_in_ack), 64'd0);
        pop_check("full_pop0", fifo_vec[0]);
        rx_wait_ack(20, c);
        check("full_ack_after_pop", 64'(net_in_ack), 64'd1);
        rx_release();
        for (int i = 1; i < 5; i++) begin
            pop_check("full_order", fifo_vec[i]);
        end
        check("full_drained", 64'(rx_valid), 64'd0);

        // Wrap: ten packets, draining after every second one
        for (int i = 0; i < 10; i++) begin
            dv = '{4'(15 - i), 2'(i + 1), 47'(32'hC0DE_0000 + i)};
            exp_q.push_back(dv);
            rx_send(mk(4'd1, dv.src, dv.typ, dv.data));
            if (i % 2 == 1) begin
                while (exp_q.size() > 0) begin
                    pop_check("wrap", exp_q.pop_front());
                end
                check("wrap_empty", 64'(rx_valid), 64'd0);
            end
        end

        // Packet addressed to another node
        rx_send(mk(4'd3, 4'd5, 2'd1, 47'h77));
        @(negedge clk);
`ifdef NI_DEST_CHECK_EN
        check("misroute_not_queued", 64'(rx_valid), 64'd0);
        check("misroute_drop_cnt",   64'(drop_cnt), 64'd1);
`else
        check("misroute_drop_cnt", 64'(drop_cnt), 64'd0);
        dv = '{4'd5, 2'd1, 47'h77};
        pop_check("misroute_delivered", dv);
`endif

        // Asynchronous reset in the middle of both handshakes
        tx_valid = 1'b1;
        tx_dst   = 4'd4;
        @(negedge clk);
        tx_valid = 1'b0;
        @(negedge clk);
        check("mid_tx_req_hi", 64'(net_out_req), 64'd1);
        rx_raise(mk(4'd1, 4'd6, 2'd2, 47'h99));
        rx_wait_ack(20, c);
        check("mid_rx_ack_hi", 64'(net_in_ack), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_req", 64'(net_out_req), 64'd0);
        check("async_rst_in_ack",  64'(net_in_ack),  64'd0);
        check("async_rst_tx_ready", 64'(tx_ready),   64'd1);
        check("async_rst_rx_valid", 64'(rx_valid),   64'd0);
        net_in_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tx_send(tx_vec[0]);
        check("post_rst_rx_empty", 64'(rx_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
